// File: rtl/keypad_pkg.sv
// Shared types, hex keypad layout and key-code helpers for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } state_t;

    // Physical 4x4 hex pad, row 0 at the top, column 0 on the left.
    localparam logic [3:0] HEX_LUT [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hC},
        '{4'h4, 4'h5, 4'h6, 4'hD},
        '{4'h7, 4'h8, 4'h9, 4'hE},
        '{4'hA, 4'h0, 4'hB, 4'hF}
    };

    function automatic int code_width(input int nrows, input int ncols, input int hex_map);
        int w;
        w = $clog2(nrows * ncols);
        return ((hex_map != 0) && (w < 4)) ? 4 : w;
    endfunction

    function automatic logic [7:0] key_encode(input int r, input int c, input int ncols,
                                              input bit hex_map);
        if (hex_map)
            return {4'h0, HEX_LUT[r[1:0]][c[1:0]]};
        return 8'(r * ncols + c);
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for the asynchronous row inputs; resets to all-ones (no key).
// Latency 2 cycles; no flow control.
module keypad_sync #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: column scan, press/release debounce, one-cycle strobe per accepted key.
// Strobe arrives DEBOUNCE_CYCLES after the stable sample; no backpressure, the consumer must take key_valid.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int NROWS           = 4,
    parameter int NCOLS           = 4,
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int HEX_MAP         = 1,
    localparam int KW             = code_width(NROWS, NCOLS, HEX_MAP)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NROWS-1:0] row_n,
    output logic [NCOLS-1:0] col_n,
    output logic             key_valid,
    output logic [KW-1:0]    key_code,
    output logic             key_held
);

    localparam int CW = $clog2(NCOLS);
    localparam int RW = $clog2(NROWS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int TW = $clog2(DEBOUNCE_CYCLES);
    localparam int NW = $clog2(NROWS + 1);

    state_t           r_state;
    logic [CW-1:0]    r_col;
    logic [DW-1:0]    r_div;
    logic [TW-1:0]    r_cnt;
    logic [NROWS-1:0] r_pat;
    logic [RW-1:0]    r_row;
    logic [NCOLS-1:0] r_col_n;
    logic             r_valid;
    logic [KW-1:0]    r_code;
    logic             r_held;

    logic [NROWS-1:0] w_rows_s;
    logic [NW-1:0]    w_nlow;
    logic [RW-1:0]    w_low_idx;
    logic [CW-1:0]    w_col_nxt;
    logic [NCOLS-1:0] w_col_n_nxt;
    logic             w_dwell_end;
    logic             w_deb_done;
    logic             w_row_up;
    logic [KW-1:0]    w_code_new;

    keypad_sync #(.W(NROWS)) u_sync (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (row_n),
        .o_q     (w_rows_s)
    );

    always_comb begin
        w_nlow    = '0;
        w_low_idx = '0;
        for (int i = 0; i < NROWS; i++) begin
            if (!w_rows_s[i]) begin
                w_nlow    = w_nlow + 1'b1;
                w_low_idx = RW'(i);
            end
        end
    end

    assign w_col_nxt   = (r_col == CW'(NCOLS - 1)) ? '0 : r_col + 1'b1;
    assign w_col_n_nxt = ~(NCOLS'(1) << w_col_nxt);
    assign w_dwell_end = (r_div == DW'(SCAN_DIV - 1));
    // The sample/HELD-detect cycle counts as the first stable cycle, so the counter stops one short.
    assign w_deb_done  = (r_cnt == TW'(DEBOUNCE_CYCLES - 2));
    assign w_row_up    = w_rows_s[r_row];
    assign w_code_new  = KW'(key_encode(int'(r_row), int'(r_col), NCOLS, HEX_MAP != 0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SCAN;
            r_col   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_pat   <= '1;
            r_row   <= '0;
            r_col_n <= {{(NCOLS-1){1'b1}}, 1'b0};
            r_valid <= 1'b0;
            r_code  <= '0;
            r_held  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (w_dwell_end) begin
                        r_div <= '0;
                        if (w_nlow == NW'(1)) begin
                            r_state <= DEB_PRESS;
                            r_pat   <= w_rows_s;
                            r_row   <= w_low_idx;
                            r_cnt   <= '0;
                        end else begin
                            r_col   <= w_col_nxt;
                            r_col_n <= w_col_n_nxt;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (w_rows_s != r_pat) begin
                        r_state <= SCAN;
                        r_cnt   <= '0;
                        r_col   <= w_col_nxt;
                        r_col_n <= w_col_n_nxt;
                    end else if (w_deb_done) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_code  <= w_code_new;
                        r_held  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (w_row_up) begin
                        r_state <= DEB_RELEASE;
                        r_cnt   <= '0;
                    end
                end
                DEB_RELEASE: begin
                    if (!w_row_up) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
                    end else if (w_deb_done) begin
                        r_state <= SCAN;
                        r_cnt   <= '0;
                        r_held  <= 1'b0;
                        r_col   <= w_col_nxt;
                        r_col_n <= w_col_n_nxt;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign col_n     = r_col_n;
    assign key_valid = r_valid;
    assign key_code  = r_code;
    assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: switch-matrix model, randomized key choices, timing predicted from scan/debounce arithmetic.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] row_n_a, col_n_a, kc_a;
    logic       kv_a, kh_a;
    logic [1:0] row_n_b;
    logic [2:0] col_n_b, kc_b;
    logic       kv_b, kh_b;

    logic [3:0] press_a [4];
    logic [2:0] press_b [2];

    int hex_tab [16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int pulses_a = 0;
    int pulses_b = 0;
    int pulse_cyc_a = 0;

    keypad_scanner #(.NROWS(4), .NCOLS(4), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .HEX_MAP(1)) dut_a (
        .clk(clk), .reset(rst_a), .row_n(row_n_a), .col_n(col_n_a),
        .key_valid(kv_a), .key_code(kc_a), .key_held(kh_a)
    );

    keypad_scanner #(.NROWS(2), .NCOLS(3), .SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .HEX_MAP(0)) dut_b (
        .clk(clk), .reset(rst_b), .row_n(row_n_b), .col_n(col_n_b),
        .key_valid(kv_b), .key_code(kc_b), .key_held(kh_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (kv_a === 1'b1) begin
            pulses_a++;
            pulse_cyc_a = cyc;
        end
        if (kv_b === 1'b1) pulses_b++;
    end

    // A row reads low when a pressed switch sits on the currently driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) row_n_a[r] = ~|(press_a[r] & ~col_n_a);
        for (int r = 0; r < 2; r++) row_n_b[r] = ~|(press_b[r] & ~col_n_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic scan_seen(output logic [3:0] seen);
        seen = '0;
        repeat (20) begin
            step(1);
            seen = seen | ~col_n_a;
        end
    endtask

    // Key held through reset: sampled on the last dwell cycle of its column, strobe DB cycles later.
    task automatic press_from_reset(input int r, input int c);
        int base, p0, lat;
        logic [3:0] exp_col;
        lat = SD * (c + 1) - 1 + DB;
        exp_col = ~(4'b0001 << c);
        press_a[r][c] = 1'b1;
        rst_a = 1'b0;
        step(2);
        p0 = pulses_a;
        rst_a = 1'b1;
        base = cyc;
        step(lat + 20);
        chk("pulse_count", 32'(pulses_a - p0), 1);
        chk("latency", 32'(pulse_cyc_a - base), 32'(lat));
        chk("code", 32'(kc_a), 32'(hex_tab[r*4+c]));
        chk("held", 32'(kh_a), 1);
        chk("col_frozen", 32'(col_n_a), 32'(exp_col));
        press_a[r][c] = 1'b0;
        step(DB + 1);
        chk("held_during_release", 32'(kh_a), 1);
        step(1);
        chk("held_released", 32'(kh_a), 0);
    endtask

    initial begin
        int r, r2, c, p0, base, blen;
        logic [3:0] seen;

        for (int i = 0; i < 4; i++) press_a[i] = '0;
        for (int i = 0; i < 2; i++) press_b[i] = '0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        step(3);
        chk("rst_col", 32'(col_n_a), 32'(4'b1110));
        chk("rst_valid", 32'(kv_a), 0);
        chk("rst_code", 32'(kc_a), 0);
        chk("rst_held", 32'(kh_a), 0);
        chk("rst_col_b", 32'(col_n_b), 32'(3'b110));
        rst_a = 1'b1;
        rst_b = 1'b1;
        step(2);

        press_from_reset(1, 2);
        repeat (4) press_from_reset($urandom_range(0, 3), $urandom_range(0, 3));

        // Reset landing on the strobe cycle clears everything at once.
        r = $urandom_range(0, 2);
        c = $urandom_range(1, 3);
        press_a[r][c] = 1'b1;
        rst_a = 1'b0;
        step(2);
        rst_a = 1'b1;
        step(SD * (c + 1) - 1 + DB);
        chk("strobe_before_reset", 32'(kv_a), 1);
        #2 rst_a = 1'b0;
        #1;
        chk("midrst_col", 32'(col_n_a), 32'(4'b1110));
        chk("midrst_valid", 32'(kv_a), 0);
        chk("midrst_code", 32'(kc_a), 0);
        chk("midrst_held", 32'(kh_a), 0);
        press_a[r][c] = 1'b0;
        step(2);
        rst_a = 1'b1;
        step(2);

        p0 = pulses_a;
        blen = $urandom_range(1, 6);
        press_a[3][1] = 1'b1;
        step(blen);
        press_a[3][1] = 1'b0;
        step(30);
        chk("bounce_no_pulse", 32'(pulses_a - p0), 0);
        chk("bounce_held", 32'(kh_a), 0);
        scan_seen(seen);
        chk("bounce_scan_resumes", 32'(seen), 32'hF);
        press_a[3][1] = 1'b1;
        step(40);
        chk("r3c1_pulse", 32'(pulses_a - p0), 1);
        chk("r3c1_code", 32'(kc_a), 0);
        press_a[3][1] = 1'b0;
        step(20);

        p0 = pulses_a;
        press_a[0][0] = 1'b1;
        step(40);
        chk("r0c0_code", 32'(kc_a), 1);
        press_a[2][3] = 1'b1;
        step(40);
        chk("second_key_ignored", 32'(pulses_a - p0), 1);
        chk("second_key_code", 32'(kc_a), 1);
        chk("second_key_col", 32'(col_n_a), 32'(4'b1110));
        press_a[0][0] = 1'b0;
        step(50);
        chk("r2c3_pulse", 32'(pulses_a - p0), 2);
        chk("r2c3_code", 32'(kc_a), 32'hE);
        chk("r2c3_held", 32'(kh_a), 1);
        press_a[2][3] = 1'b0;
        step(20);
        chk("r2c3_released", 32'(kh_a), 0);

        p0 = pulses_a;
        c = $urandom_range(0, 3);
        r = $urandom_range(0, 3);
        r2 = (r + $urandom_range(1, 3)) % 4;
        press_a[r][c] = 1'b1;
        press_a[r2][c] = 1'b1;
        step(60);
        chk("ghost_no_pulse", 32'(pulses_a - p0), 0);
        chk("ghost_held", 32'(kh_a), 0);
        scan_seen(seen);
        chk("ghost_scan_continues", 32'(seen), 32'hF);
        press_a[r][c] = 1'b0;
        press_a[r2][c] = 1'b0;
        step(10);

        press_b[1][2] = 1'b1;
        step(50);
        chk("b_pulse", 32'(pulses_b), 1);
        chk("b_code", 32'(kc_b), 5);
        chk("b_held", 32'(kh_b), 1);
        chk("b_col_frozen", 32'(col_n_b), 32'(3'b011));
        #2 rst_b = 1'b0;
        #1;
        chk("b_rst_col", 32'(col_n_b), 32'(3'b110));
        chk("b_rst_code", 32'(kc_b), 0);
        chk("b_rst_held", 32'(kh_b), 0);
        chk("b_rst_valid", 32'(kv_b), 0);
        press_b[1][2] = 1'b0;
        step(2);
        rst_b = 1'b1;
        base = cyc;
        step(SD - 1);
        chk("b_restart_col0", 32'(col_n_b), 32'(3'b110));
        step(1);
        chk("b_restart_col1", 32'(col_n_b), 32'(3'b101));
        chk("b_restart_edges", 32'(cyc - base), 32'(SD));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
